// File: rtl/spi_pkg.sv
// Shared types and default sizes for the SPI register-access sequencer.
// Command bundle, sequencer states and a small sizing helper.
package spi_pkg;

  localparam int SPI_ADDR_W   = 6;
  localparam int SPI_DATA_W   = 8;
  localparam int SPI_DEPTH    = 4;
  localparam int SPI_COOLDOWN = 20;
  localparam int SPI_TIMEOUT  = 64;

  typedef struct packed {
    logic                  write;
    logic [SPI_ADDR_W-1:0] addr;
    logic [SPI_DATA_W-1:0] wdata;
  } spi_txn_t;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_ISSUE,
    SEQ_WAIT_DONE,
    SEQ_RESPOND,
    SEQ_COOLDOWN
  } spi_seq_state_t;

  function automatic int spi_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// First-word fall-through command FIFO of spi_txn_t.
// Power-of-two depth; pointers wrap naturally.
module spi_cmd_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = SPI_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  spi_txn_t      push_data_i,
  input  logic          pop_i,
  output spi_txn_t      pop_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  spi_txn_t      mem_q [DEPTH];
  logic          push, pop;

  assign full_o     = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign level_o    = cnt_q;
  assign pop_data_o = mem_q[rptr_q];
  assign push       = push_i & ~full_o;
  assign pop        = pop_i & ~empty_o;

  // Pointer and occupancy update for accepted push/pop.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry write on accepted push.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Register-access sequencer in front of the SPI main engine.
// Queues commands, drives the engine, returns one response each.
module spi_txn_sequencer
  import spi_pkg::*;
#(
  // Address/data widths must match the spi_txn_t fields in spi_pkg.
  parameter int ADDR_WIDTH      = SPI_ADDR_W,
  parameter int DATA_WIDTH      = SPI_DATA_W,
  parameter int DEPTH           = SPI_DEPTH,
  parameter int COOLDOWN_CYCLES = SPI_COOLDOWN,
  parameter int TIMEOUT_CYCLES  = SPI_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [DATA_WIDTH-1:0]    cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_write,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_error,
  output logic                     eng_en,
  output logic                     eng_mode,
  output logic [ADDR_WIDTH-1:0]    eng_rw_addr,
  output logic [DATA_WIDTH-1:0]    eng_write_data,
  output logic                     eng_write_valid,
  input  logic [DATA_WIDTH-1:0]    eng_read_data,
  input  logic                     eng_read_valid,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int CNT_MAX = spi_max(COOLDOWN_CYCLES, TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] ISSUE_LAST = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CD_LAST    = CNT_W'(COOLDOWN_CYCLES - 1);

  spi_txn_t       fifo_in, fifo_head;
  logic           fifo_full, fifo_empty, fifo_pop;

  spi_seq_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           cur_write_q, cur_write_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [DATA_WIDTH-1:0] cur_wdata_q, cur_wdata_d;
  logic           eng_en_q, eng_en_d;
  logic           ewv_q, ewv_d;
  logic           rv_q;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic           rsp_error_q, rsp_error_d;
  logic           done_edge;

  assign fifo_in.write = cmd_write;
  assign fifo_in.addr  = cmd_addr;
  assign fifo_in.wdata = cmd_wdata;

  spi_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (cmd_valid),
    .push_data_i (fifo_in),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level)
  );

  assign cmd_ready       = ~fifo_full;
  assign busy            = (state_q != SEQ_IDLE) | ~fifo_empty;
  assign eng_en          = eng_en_q;
  assign eng_mode        = cur_write_q;
  assign eng_rw_addr     = cur_addr_q;
  assign eng_write_data  = cur_wdata_q;
  assign eng_write_valid = ewv_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_write       = rsp_write_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_error       = rsp_error_q;

  // A fresh rise of the engine's done flag marks completion.
  assign done_edge = eng_read_valid & ~rv_q;

  // Sequencer next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_write_d = cur_write_q;
    cur_addr_d  = cur_addr_q;
    cur_wdata_d = cur_wdata_q;
    eng_en_d    = eng_en_q;
    ewv_d       = ewv_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    fifo_pop    = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          cur_write_d = fifo_head.write;
          cur_addr_d  = fifo_head.addr;
          cur_wdata_d = fifo_head.wdata;
          eng_en_d    = 1'b1;
          ewv_d       = fifo_head.write;
          cnt_d       = '0;
          state_d     = SEQ_ISSUE;
        end
      end
      SEQ_ISSUE: begin
        if (cnt_q == ISSUE_LAST) begin
          eng_en_d = 1'b0;
          cnt_d    = '0;
          state_d  = SEQ_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SEQ_WAIT_DONE: begin
        if (done_edge) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = cur_write_q;
          rsp_rdata_d = cur_write_q ? '0 : eng_read_data;
          rsp_error_d = 1'b0;
          ewv_d       = 1'b0;
          state_d     = SEQ_RESPOND;
        end else if (cnt_q == TO_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = cur_write_q;
          rsp_rdata_d = '0;
          rsp_error_d = 1'b1;
          ewv_d       = 1'b0;
          state_d     = SEQ_RESPOND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SEQ_RESPOND: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = SEQ_COOLDOWN;
        end
      end
      SEQ_COOLDOWN: begin
        if (cnt_q == CD_LAST) begin
          cnt_d   = '0;
          state_d = SEQ_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d     = SEQ_IDLE;
        cnt_d       = '0;
        eng_en_d    = 1'b0;
        ewv_d       = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State, command, engine-drive and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEQ_IDLE;
      cnt_q       <= '0;
      cur_write_q <= 1'b0;
      cur_addr_q  <= '0;
      cur_wdata_q <= '0;
      eng_en_q    <= 1'b0;
      ewv_q       <= 1'b0;
      rv_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_write_q <= cur_write_d;
      cur_addr_q  <= cur_addr_d;
      cur_wdata_q <= cur_wdata_d;
      eng_en_q    <= eng_en_d;
      ewv_q       <= ewv_d;
      rv_q        <= eng_read_valid;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

endmodule
